// File: rtl/archel_vram_pkg.sv
// Shared definitions for the VRAM row arbiter.
// Holds the default row address and row data widths and the arbiter state encoding.
package archel_vram_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 640;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT_WR,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/vram_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - index of the highest-priority requester for this pick
//   gnt_o  - one-hot vector with the first set request at or after ptr_i, wrapping
//   any_o  - at least one request is set
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             any_o
);

  // Walk the requesters starting at the pointer and take the first one that
  // is asking; the modulo makes the search wrap past the last requester.
  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM row arbiter: grants one requester at a time a
// read-modify-write of one scanline row on VRAM port A.
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   req, req_addr,
//   req_wdata, req_wvalid - flattened per-requester request buses
//   grant                 - one-hot grant of the transaction owner
//   rd_data, rd_valid     - row read back for the owner (one-cycle valid)
//   done, timeout         - write committed / transaction aborted pulses
//   vram_addr, vram_wdata,
//   vram_we, vram_rdata   - VRAM port A
module vram_arbiter
  import archel_vram_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  input  logic [N_REQ-1:0]         req_wvalid,
  output logic [N_REQ-1:0]         grant,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     done,
  output logic                     timeout,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [DATA_W-1:0]        vram_wdata,
  output logic                     vram_we,
  input  logic [DATA_W-1:0]        vram_rdata
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [2:0]       RD_LAST  = 3'(RD_LAT);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]  vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [DATA_W-1:0]  vram_wdata_q, vram_wdata_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               vram_we_q, vram_we_d;
  logic [2:0]         rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic               pick_any;
  logic [PTR_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  pick_addr;
  logic               sel_req;
  logic               sel_wvalid;
  logic [DATA_W-1:0]  sel_wdata;
  logic [PTR_W-1:0]   next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .any_o (pick_any)
  );

  // Decode the flattened buses: the winner's address for a new grant, and
  // the owner's request/write signals while a transaction is in flight.
  always_comb begin
    pick_idx   = '0;
    pick_addr  = '0;
    sel_req    = 1'b0;
    sel_wvalid = 1'b0;
    sel_wdata  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = PTR_W'(i);
        pick_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
      if (gidx_q == PTR_W'(i)) begin
        sel_req    = req[i];
        sel_wvalid = req_wvalid[i];
        sel_wdata  = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Priority moves to the requester after the one just served.
  assign next_ptr = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  // Next-state and registered-output logic. Pulses default low; every
  // visible output is computed here one cycle ahead so that it comes
  // straight out of a flop.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    vram_addr_d  = vram_addr_q;
    rd_data_d    = rd_data_q;
    vram_wdata_d = vram_wdata_q;
    rd_cnt_d     = rd_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    vram_we_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_gnt;
          gidx_d      = pick_idx;
          vram_addr_d = pick_addr;
          rd_cnt_d    = '0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        // The read runs to completion regardless of the requester's req.
        if (rd_cnt_q == RD_LAST) begin
          rd_data_d  = vram_rdata;
          rd_valid_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT_WR;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_WAIT_WR: begin
        if (sel_wvalid) begin
          vram_wdata_d = sel_wdata;
          vram_we_d    = 1'b1;
          done_d       = 1'b1;
          state_d      = ST_WRITE;
        end else if (!sel_req) begin
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          rr_ptr_d  = next_ptr;
          state_d   = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        grant_d  = '0;
        rr_ptr_d = next_ptr;
        state_d  = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately, so a
  // write in progress is cut off without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gidx_q       <= '0;
      grant_q      <= '0;
      vram_addr_q  <= '0;
      rd_data_q    <= '0;
      vram_wdata_q <= '0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      vram_we_q    <= 1'b0;
      rd_cnt_q     <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      vram_addr_q  <= vram_addr_d;
      rd_data_q    <= rd_data_d;
      vram_wdata_q <= vram_wdata_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      vram_we_q    <= vram_we_d;
      rd_cnt_q     <= rd_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;
  assign vram_we    = vram_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with two requesters, RD_LAT=2 and
// TIMEOUT=4. Cycle numbers in the comments count clock edges after the
// request is raised (cycle 0 = request cycle).
module tb_vram_arbiter;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req = '0;
  logic [17:0]   req_addr = '0;
  logic [1279:0] req_wdata = '0;
  logic [1:0]    req_wvalid = '0;
  logic [1:0]    grant;
  logic [639:0]  rd_data;
  logic          rd_valid;
  logic          done;
  logic          timeout;
  logic [8:0]    vram_addr;
  logic [639:0]  vram_wdata;
  logic          vram_we;
  logic [639:0]  vram_rdata;

  int assertCount = 0;
  int failCount = 0;

  vram_arbiter #(
    .N_REQ   (2),
    .ADDR_W  (9),
    .DATA_W  (640),
    .RD_LAT  (2),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wvalid (req_wvalid),
    .grant      (grant),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .done       (done),
    .timeout    (timeout),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_rdata (vram_rdata)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // VRAM contents: an 0xA5 pattern with the row address folded into the low bits.
  function automatic logic [639:0] rowOf(input logic [8:0] a);
    logic [639:0] pat;
    pat = {80{8'hA5}};
    return pat ^ {631'b0, a};
  endfunction

  assign vram_rdata = rowOf(vram_addr);

  // Single comparison point: counts, and reports mismatches.
  task automatic checkOutput(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] wv);
    req        = r;
    req_wvalid = wv;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse; returns 1 ns after an edge with rst_n high (cycle 0).
  task automatic doReset();
    applyStimulus(2'b00, 2'b00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values.
    #2 rst_n = 1'b0;
    #2;
    checkOutput("rst_grant", 640'(grant), 640'd0);
    checkOutput("rst_rd_valid", 640'(rd_valid), 640'd0);
    checkOutput("rst_done", 640'(done), 640'd0);
    checkOutput("rst_timeout", 640'(timeout), 640'd0);
    checkOutput("rst_vram_we", 640'(vram_we), 640'd0);
    checkOutput("rst_vram_addr", 640'(vram_addr), 640'd0);
    checkOutput("rst_rd_data", rd_data, 640'd0);
    checkOutput("rst_vram_wdata", vram_wdata, 640'd0);

    // Single transaction from requester 0, addr 9'h012, writes 640'h1.
    doReset();
    req_addr  = {9'h0AB, 9'h012};
    req_wdata = {640'd2, 640'd1};
    applyStimulus(2'b01, 2'b00);
    for (int c = 1; c <= 6; c++) begin
      step();
      checkOutput($sformatf("t1_grant_c%0d", c), 640'(grant), (c <= 5) ? 640'd1 : 640'd0);
      checkOutput($sformatf("t1_rd_valid_c%0d", c), 640'(rd_valid), 640'(c == 4));
      checkOutput($sformatf("t1_vram_we_c%0d", c), 640'(vram_we), 640'(c == 5));
      checkOutput($sformatf("t1_done_c%0d", c), 640'(done), 640'(c == 5));
      checkOutput($sformatf("t1_timeout_c%0d", c), 640'(timeout), 640'd0);
      if (c == 1) checkOutput("t1_addr_read", 640'(vram_addr), 640'h012);
      if (c == 2) req_addr = {9'h0AB, 9'h1FF};
      if (c == 4) begin
        checkOutput("t1_rd_data", rd_data, rowOf(9'h012));
        req_wvalid = 2'b01;
      end
      if (c == 5) begin
        checkOutput("t1_addr_write", 640'(vram_addr), 640'h012);
        checkOutput("t1_wdata", vram_wdata, 640'h1);
        applyStimulus(2'b00, 2'b00);
      end
    end

    // Both requesters always asking and always ready to write.
    doReset();
    req_wdata = {640'd2, 640'd1};
    applyStimulus(2'b11, 2'b11);
    for (int c = 1; c <= 19; c++) begin
      int phase;
      int k;
      step();
      phase = (c - 1) % 6;
      k = (c - 1) / 6;
      checkOutput($sformatf("t2_grant_c%0d", c), 640'(grant),
                  (phase == 5) ? 640'd0 : ((k % 2 == 0) ? 640'd1 : 640'd2));
      checkOutput($sformatf("t2_rd_valid_c%0d", c), 640'(rd_valid), 640'(phase == 3));
      checkOutput($sformatf("t2_vram_we_c%0d", c), 640'(vram_we), 640'(phase == 4));
      if (phase == 4)
        checkOutput($sformatf("t2_wdata_c%0d", c), vram_wdata, (k % 2 == 0) ? 640'd1 : 640'd2);
    end

    // Requester 1 releases in WAIT_WR without writing.
    doReset();
    applyStimulus(2'b10, 2'b00);
    for (int c = 1; c <= 5; c++) begin
      step();
      checkOutput($sformatf("t3_grant_c%0d", c), 640'(grant), (c <= 4) ? 640'd2 : 640'd0);
      checkOutput($sformatf("t3_vram_we_c%0d", c), 640'(vram_we), 640'd0);
      checkOutput($sformatf("t3_done_c%0d", c), 640'(done), 640'd0);
      if (c == 4) begin
        checkOutput("t3_rd_valid", 640'(rd_valid), 640'd1);
        applyStimulus(2'b00, 2'b00);
      end
      if (c == 5) applyStimulus(2'b11, 2'b00);
    end
    step();
    checkOutput("t3_ptr_after_release", 640'(grant), 640'd1);

    // Requester 0 never writes: abort after 4 WAIT_WR cycles.
    doReset();
    applyStimulus(2'b01, 2'b00);
    for (int c = 1; c <= 9; c++) begin
      step();
      checkOutput($sformatf("t4_timeout_c%0d", c), 640'(timeout), 640'(c == 8));
      checkOutput($sformatf("t4_vram_we_c%0d", c), 640'(vram_we), 640'd0);
      checkOutput($sformatf("t4_done_c%0d", c), 640'(done), 640'd0);
      checkOutput($sformatf("t4_grant_c%0d", c), 640'(grant),
                  (c <= 7) ? 640'd1 : ((c == 9) ? 640'd2 : 640'd0));
      if (c == 8) applyStimulus(2'b11, 2'b00);
    end

    // Reset asserted during WRITE.
    doReset();
    req_wdata = {640'd2, 640'd1};
    applyStimulus(2'b01, 2'b01);
    repeat (5) step();
    checkOutput("t5_we_in_write", 640'(vram_we), 640'd1);
    applyStimulus(2'b10, 2'b00);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_we_async", 640'(vram_we), 640'd0);
    checkOutput("t5_grant_async", 640'(grant), 640'd0);
    checkOutput("t5_done_async", 640'(done), 640'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("t5_grant_after", 640'(grant), 640'd2);
    checkOutput("t5_done_after", 640'(done), 640'd0);
    applyStimulus(2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
